dmu_port_arbiter: RTL and testbench
===================================

Name: dmu_port_arbiter

Overview:
- Shares the single data-memory unit port between two requesters: port 0 (CPU load/store stage) and port 1 (debug/PDU memory access).
- Decodes each access to data memory or the I/O bus (addr[15:8] == 8'hFF selects I/O).
- Sequences each access through a request/grant/response handshake and returns read data with a registered valid pulse.
- Sits between the requester ports and the data-memory unit's dm_*/io_* signal groups.

Parameters:
- IO_PAGE, 8'hFF, value of addr[15:8] that selects the I/O bus
- RR_EN_DEFAULT, 1, reset value of round-robin enable (0 = fixed priority, port 0 wins)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rr_en  in  1  1 = round-robin arbitration, 0 = fixed priority (sampled each IDLE cycle)
- p0_req, p1_req  in  1  access request; held until gnt
- p0_we, p1_we  in  1  1 = write, 0 = read
- p0_mode, p1_mode  in  3  width/sign mode forwarded to dm_mode
- p0_addr, p1_addr  in  32  byte address
- p0_wdata, p1_wdata  in  32  write data
- p0_gnt, p1_gnt  out  1  one-cycle pulse; request fields captured this cycle
- p0_rvalid, p1_rvalid  out  1  one-cycle response pulse; asserted for writes too
- p0_rdata, p1_rdata  out  32  read data, valid with rvalid, held until next response to that port
- p_err  out  1  dm_error captured with the response
- dm_we  out  1  memory write enable
- dm_mode  out  3  memory mode
- dm_addr  out  32  memory address
- dm_din  out  32  memory write data
- dm_dout  in  32  memory read data (synchronous, valid the cycle after ACC)
- dm_error  in  1  memory misalignment/range error
- io_addr  out  16  I/O address
- io_dout  out  32  I/O write data
- io_we, io_rd  out  1  I/O strobes
- io_din  in  32  I/O read data

Behaviour:
- Reset:
  - state = IDLE, last_gnt = 1 (port 0 wins first tie).
  - All outputs 0; rdata registers 0.
- FSM states:
  - IDLE -> ACC on any req. Grant decision in IDLE (combinational): gnt pulses, and owner, we, mode, addr and wdata are registered.
  - ACC (1 cycle):
    - DM target: drive dm_* from the latched fields; dm_we = latched we.
    - IO target: drive io_addr = addr[15:0], io_dout, io_we = we, io_rd = ~we; dm_we forced 0.
  - ACC -> RESP unconditionally.
  - RESP (1 cycle):
    - Capture dm_dout or io_din into the owner's rdata; rvalid pulses on the owner only.
    - p_err = dm_error for DM accesses, 0 for IO accesses.
  - RESP -> IDLE.
- Outside ACC, all dm_*/io_* strobes are 0; addresses and data hold their last values.
- Latency and throughput:
  - Request to gnt: same cycle if IDLE.
  - gnt to rvalid: 2 cycles.
  - Peak throughput: one access per 3 cycles.
- Arbitration:
  - Both requesting with rr_en = 1: grant the port != last_gnt.
  - Both requesting with rr_en = 0: port 0 wins.
  - last_gnt updates on every grant.
- Request handling:
  - Requests arriving in ACC/RESP are not granted and must be held by the requester.
  - A req dropped before gnt is legal and is simply ignored.
- Reset mid-access returns to IDLE immediately; no rvalid is issued and no strobe is driven after reset asserts.

Optional Feature:
- DMU_ARB_STATS_EN:
  - Defined: adds outputs p0_cnt and p1_cnt (each 32-bit) and io_cnt (16-bit), counting grants per port and IO accesses.
  - Counters wrap modulo 2^width, reset to 0, and increment in the gnt cycle.
  - Undefined: no extra ports or registers; behaviour is otherwise identical.

Test Plan:
- Single read: p0 read of addr 0x0000_0010 with dm_dout = 32'hDEADBEEF in RESP -> p0_gnt at cycle t, dm_addr = 0x10 and dm_we = 0 at t+1, p0_rvalid with p0_rdata = DEADBEEF at t+2.
- IO write: p1 write of addr 0x0000_FF04, wdata 0x5A -> io_we = 1, io_addr = 16'hFF04, io_dout = 0x5A in ACC; dm_we = 0 throughout; p1_rvalid at t+2.
- Contention, round-robin: both ports requesting continuously with rr_en = 1 -> grant order 0, 1, 0, 1, each gnt 3 cycles apart.
- Contention, fixed priority: same stimulus with rr_en = 0 -> p0 granted every slot; p1 never granted while p0_req stays high.
- Error/reset: dm_error = 1 during RESP -> p_err = 1 with rvalid. Separately, rstn asserted in ACC -> all strobes 0 in the same cycle and no rvalid follows.
- Stats (DMU_ARB_STATS_EN defined): 5 p0 grants and 3 p1 grants, 2 of which are IO accesses -> p0_cnt = 5, p1_cnt = 3, io_cnt = 2.

Source files
------------

// File: rtl/dmu_port_arbiter.sv
// dmu_port_arbiter
//   Shares the data-memory unit port between two requesters: port 0 (CPU
//   load/store stage) and port 1 (debug/PDU memory access). Every access runs
//   IDLE -> ACC -> RESP. The grant is decided combinationally in IDLE. ACC drives
//   either the dm_* group or the io_* group, depending on whether addr[15:8]
//   equals IO_PAGE. RESP returns the read data to the owning port with a
//   one-cycle rvalid pulse.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   rr_en                1 = round-robin, 0 = fixed priority (port 0 wins)
//   pN_req/we/mode/addr/wdata   requester N access fields (held until gnt)
//   pN_gnt               grant pulse; request fields are captured this cycle
//   pN_rvalid/rdata      response pulse and read data (data held afterwards)
//   p_err                dm_error reported together with a DM response
//   dm_we/mode/addr/din, dm_dout, dm_error   data-memory side
//   io_addr/dout/we/rd, io_din               I/O bus side
//
// Optional build macro
//   DMU_ARB_STATS_EN     adds p0_cnt/p1_cnt (grants per port) and io_cnt
//                        (I/O accesses). Counters wrap and count in the gnt cycle.
module dmu_port_arbiter #(
    parameter logic [7:0] IO_PAGE       = 8'hFF,
    parameter bit         RR_EN_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rr_en,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [2:0]  p0_mode,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [2:0]  p1_mode,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic        p_err,
`ifdef DMU_ARB_STATS_EN
    output logic [31:0] p0_cnt,
    output logic [31:0] p1_cnt,
    output logic [15:0] io_cnt,
`endif
    output logic        dm_we,
    output logic [2:0]  dm_mode,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout,
    input  logic        dm_error,
    output logic [15:0] io_addr,
    output logic [31:0] io_dout,
    output logic        io_we,
    output logic        io_rd,
    input  logic [31:0] io_din
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;        // port granted most recently
    logic        rr_q, rr_d;            // arbitration mode sampled in IDLE
    logic        owner_q, owner_d;
    logic        is_io_q, is_io_d;
    logic        dm_we_q, dm_we_d;
    logic [2:0]  dm_mode_q, dm_mode_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_din_q, dm_din_d;
    logic [15:0] io_addr_q, io_addr_d;
    logic [31:0] io_dout_q, io_dout_d;
    logic        io_we_q, io_we_d;
    logic        io_rd_q, io_rd_d;
    logic [1:0]  rvalid_q, rvalid_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        gnt0, gnt1, gnt_any;
    logic        sel_we, sel_io;
    logic [2:0]  sel_mode;
    logic [31:0] sel_addr, sel_wdata;
    logic [31:0] resp_data;

    // Grant decision. Reset masks it, so no grant shows while rstn is low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rstn && state_q == ST_IDLE) begin
            if (p0_req && p1_req) begin
                // Round-robin hands the slot to the port that did not win last.
                gnt1 = rr_q & ~last_q;
                gnt0 = ~gnt1;
            end else begin
                gnt0 = p0_req;
                gnt1 = p1_req;
            end
        end
    end

    assign gnt_any   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? p1_we    : p0_we;
    assign sel_mode  = gnt1 ? p1_mode  : p0_mode;
    assign sel_addr  = gnt1 ? p1_addr  : p0_addr;
    assign sel_wdata = gnt1 ? p1_wdata : p0_wdata;
    assign sel_io    = (sel_addr[15:8] == IO_PAGE);
    assign resp_data = is_io_q ? io_din : dm_dout;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        is_io_d   = is_io_q;
        dm_mode_d = dm_mode_q;
        dm_addr_d = dm_addr_q;
        dm_din_d  = dm_din_q;
        io_addr_d = io_addr_q;
        io_dout_d = io_dout_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        // Strobes and rvalid are single-cycle pulses.
        dm_we_d   = 1'b0;
        io_we_d   = 1'b0;
        io_rd_d   = 1'b0;
        rvalid_d  = 2'b00;
        case (state_q)
            ST_IDLE: begin
                rr_d = rr_en;
                if (gnt_any) begin
                    state_d = ST_ACC;
                    last_d  = gnt1;
                    owner_d = gnt1;
                    is_io_d = sel_io;
                    // Only the targeted bus group is loaded. The other group
                    // keeps showing its last access.
                    if (sel_io) begin
                        io_addr_d = sel_addr[15:0];
                        io_dout_d = sel_wdata;
                        io_we_d   = sel_we;
                        io_rd_d   = ~sel_we;
                    end else begin
                        dm_addr_d = sel_addr;
                        dm_mode_d = sel_mode;
                        dm_din_d  = sel_wdata;
                        dm_we_d   = sel_we;
                    end
                end
            end
            ST_ACC: begin
                state_d  = ST_RESP;
                rvalid_d = owner_q ? 2'b10 : 2'b01;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (owner_q) begin
                    rdata1_d = resp_data;
                end else begin
                    rdata0_d = resp_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            rr_q      <= RR_EN_DEFAULT;
            owner_q   <= 1'b0;
            is_io_q   <= 1'b0;
            dm_we_q   <= 1'b0;
            dm_mode_q <= 3'd0;
            dm_addr_q <= 32'd0;
            dm_din_q  <= 32'd0;
            io_addr_q <= 16'd0;
            io_dout_q <= 32'd0;
            io_we_q   <= 1'b0;
            io_rd_q   <= 1'b0;
            rvalid_q  <= 2'b00;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            rr_q      <= rr_d;
            owner_q   <= owner_d;
            is_io_q   <= is_io_d;
            dm_we_q   <= dm_we_d;
            dm_mode_q <= dm_mode_d;
            dm_addr_q <= dm_addr_d;
            dm_din_q  <= dm_din_d;
            io_addr_q <= io_addr_d;
            io_dout_q <= io_dout_d;
            io_we_q   <= io_we_d;
            io_rd_q   <= io_rd_d;
            rvalid_q  <= rvalid_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

`ifdef DMU_ARB_STATS_EN
    logic [31:0] p0_cnt_q, p0_cnt_d;
    logic [31:0] p1_cnt_q, p1_cnt_d;
    logic [15:0] io_cnt_q, io_cnt_d;

    always_comb begin
        p0_cnt_d = p0_cnt_q + {31'd0, gnt0};
        p1_cnt_d = p1_cnt_q + {31'd0, gnt1};
        io_cnt_d = io_cnt_q + {15'd0, gnt_any & sel_io};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            p0_cnt_q <= 32'd0;
            p1_cnt_q <= 32'd0;
            io_cnt_q <= 16'd0;
        end else begin
            p0_cnt_q <= p0_cnt_d;
            p1_cnt_q <= p1_cnt_d;
            io_cnt_q <= io_cnt_d;
        end
    end

    assign p0_cnt = p0_cnt_q;
    assign p1_cnt = p1_cnt_q;
    assign io_cnt = io_cnt_q;
`endif

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    // The response cycle shows the live read data. After that, the captured copy is shown.
    assign p0_rdata  = rvalid_q[0] ? resp_data : rdata0_q;
    assign p1_rdata  = rvalid_q[1] ? resp_data : rdata1_q;
    assign p_err     = (rvalid_q != 2'b00) & ~is_io_q & dm_error;
    assign dm_we     = dm_we_q;
    assign dm_mode   = dm_mode_q;
    assign dm_addr   = dm_addr_q;
    assign dm_din    = dm_din_q;
    assign io_addr   = io_addr_q;
    assign io_dout   = io_dout_q;
    assign io_we     = io_we_q;
    assign io_rd     = io_rd_q;

endmodule

// File: tb/tb_dmu_port_arbiter.sv
// Randomized bench for dmu_port_arbiter. A transaction-level model predicts
// the outputs of every cycle. It tracks the cycle when the port is free
// again, the cycle of the current access and the values shown on the buses.
module tb_dmu_port_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, rr_en;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [2:0]  p0_mode, p1_mode;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        dm_we, io_we, io_rd, dm_error;
    logic [2:0]  dm_mode;
    logic [31:0] dm_addr, dm_din, dm_dout, io_dout, io_din;
    logic [15:0] io_addr;
`ifdef DMU_ARB_STATS_EN
    logic [31:0] p0_cnt, p1_cnt;
    logic [15:0] io_cnt;
`endif

    dmu_port_arbiter dut (
        .clk(clk), .rstn(rstn), .rr_en(rr_en),
        .p0_req(p0_req), .p0_we(p0_we), .p0_mode(p0_mode),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_mode(p1_mode),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p_err(p_err),
`ifdef DMU_ARB_STATS_EN
        .p0_cnt(p0_cnt), .p1_cnt(p1_cnt), .io_cnt(io_cnt),
`endif
        .dm_we(dm_we), .dm_mode(dm_mode), .dm_addr(dm_addr), .dm_din(dm_din),
        .dm_dout(dm_dout), .dm_error(dm_error),
        .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we), .io_rd(io_rd),
        .io_din(io_din)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Requester state.
    logic        req_s[2];
    logic        we_s[2];
    logic [2:0]  mode_s[2];
    logic [31:0] addr_s[2];
    logic [31:0] wdata_s[2];
    int          req_pct, drop_pct, rr_flip_pct;

    // Reference model state.
    int          cyc, busy_until, acc_cyc;
    logic        rr_s, last;
    int          m_owner;
    logic        m_we, m_io;
    logic [31:0] e_dm_addr, e_dm_din, e_io_dout, e_rdata[2];
    logic [2:0]  e_dm_mode;
    logic [15:0] e_io_addr;
    logic [31:0] n_gnt[2];
    logic [15:0] n_io;

    task automatic model_reset();
        busy_until = cyc;
        acc_cyc    = -10;
        rr_s       = 1'b1;
        last       = 1'b1;
        m_owner    = 0;
        m_we       = 1'b0;
        m_io       = 1'b0;
        e_dm_addr  = '0; e_dm_din = '0; e_dm_mode = '0;
        e_io_addr  = '0; e_io_dout = '0;
        e_rdata[0] = '0; e_rdata[1] = '0;
        n_gnt[0]   = '0; n_gnt[1] = '0; n_io = '0;
        for (int i = 0; i < 2; i++) req_s[i] = 1'b0;
    endtask

    task automatic apply();
        p0_req = req_s[0]; p0_we = we_s[0]; p0_mode = mode_s[0];
        p0_addr = addr_s[0]; p0_wdata = wdata_s[0];
        p1_req = req_s[1]; p1_we = we_s[1]; p1_mode = mode_s[1];
        p1_addr = addr_s[1]; p1_wdata = wdata_s[1];
    endtask

    task automatic drive();
        logic [31:0] a;
        for (int i = 0; i < 2; i++) begin
            if (!req_s[i]) begin
                if ($urandom_range(99) < req_pct) begin
                    req_s[i]   = 1'b1;
                    we_s[i]    = 1'($urandom_range(1));
                    mode_s[i]  = 3'($urandom_range(7));
                    a          = $urandom;
                    if ($urandom_range(1) == 1) a[15:8] = 8'hFF;
                    addr_s[i]  = a;
                    wdata_s[i] = $urandom;
                end
            end else if ($urandom_range(99) < drop_pct) begin
                req_s[i] = 1'b0;
            end
        end
        if ($urandom_range(99) < rr_flip_pct) rr_en = ~rr_en;
        dm_dout  = $urandom;
        io_din   = $urandom;
        dm_error = ($urandom_range(3) == 0);
        apply();
    endtask

    // Compare one cycle against the model, then advance the model.
    task automatic check_cycle();
        int          w;
        logic        idle, acc, resp;
        logic [31:0] rd;
        idle = (cyc >= busy_until);
        acc  = (cyc == acc_cyc);
        resp = (cyc == acc_cyc + 1);
        w = -1;
        if (idle) begin
            if (req_s[0] && req_s[1]) w = (rr_s && !last) ? 1 : 0;
            else if (req_s[0]) w = 0;
            else if (req_s[1]) w = 1;
        end
        rd = m_io ? io_din : dm_dout;
        check_eq("p0_gnt", p0_gnt, w == 0);
        check_eq("p1_gnt", p1_gnt, w == 1);
        check_eq("dm_we", dm_we, acc && !m_io && m_we);
        check_eq("io_we", io_we, acc && m_io && m_we);
        check_eq("io_rd", io_rd, acc && m_io && !m_we);
        check_eq("dm_addr", dm_addr, e_dm_addr);
        check_eq("dm_mode", dm_mode, e_dm_mode);
        check_eq("dm_din", dm_din, e_dm_din);
        check_eq("io_addr", io_addr, e_io_addr);
        check_eq("io_dout", io_dout, e_io_dout);
        check_eq("p0_rvalid", p0_rvalid, resp && m_owner == 0);
        check_eq("p1_rvalid", p1_rvalid, resp && m_owner == 1);
        check_eq("p0_rdata", p0_rdata, (resp && m_owner == 0) ? rd : e_rdata[0]);
        check_eq("p1_rdata", p1_rdata, (resp && m_owner == 1) ? rd : e_rdata[1]);
        check_eq("p_err", p_err, resp && !m_io && dm_error);
        if (resp) begin
            e_rdata[m_owner] = rd;
            $display("txn cyc=%0d port=%0d %s %s data=%h err=%0d", cyc, m_owner,
                     m_we ? "WR" : "RD", m_io ? "IO" : "DM", rd, !m_io && dm_error);
        end
        if (idle) rr_s = rr_en;
        if (w >= 0) begin
            last       = (w == 1);
            m_owner    = w;
            m_we       = we_s[w];
            m_io       = (addr_s[w][15:8] == 8'hFF);
            acc_cyc    = cyc + 1;
            busy_until = cyc + 3;
            n_gnt[w]   = n_gnt[w] + 32'd1;
            if (m_io) begin
                e_io_addr = addr_s[w][15:0];
                e_io_dout = wdata_s[w];
                n_io      = n_io + 16'd1;
            end else begin
                e_dm_addr = addr_s[w];
                e_dm_mode = mode_s[w];
                e_dm_din  = wdata_s[w];
            end
            req_s[w] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        #1;
        check_cycle();
        cyc++;
    endtask

    task automatic run(input int n, input int rp, input int dp, input int fp);
        req_pct = rp; drop_pct = dp; rr_flip_pct = fp;
        for (int i = 0; i < n; i++) step();
    endtask

    // Load a fixed request on a port, then let it run to completion.
    task automatic directed(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        req_s[p] = 1'b1; we_s[p] = we; mode_s[p] = 3'd2; addr_s[p] = a; wdata_s[p] = d;
        run(4, 0, 0, 0);
    endtask

    task automatic reset_mid_access();
        int n = 0;
        req_pct = 60; drop_pct = 0; rr_flip_pct = 0;
        while (acc_cyc != cyc && n < 200) begin
            step();
            n++;
        end
        check_eq("rst_wait_grant", n < 200, 1'b1);
        @(posedge clk);
        #2;
        check_eq("rst_pre_dm_we", dm_we, !m_io && m_we);
        check_eq("rst_pre_io_rd", io_rd, m_io && !m_we);
        rstn = 1'b0;
        #1;
        check_eq("rst_dm_we", dm_we, 1'b0);
        check_eq("rst_io_we", io_we, 1'b0);
        check_eq("rst_io_rd", io_rd, 1'b0);
        req_s[0] = 1'b1; req_s[1] = 1'b1;
        apply();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_gnt", {p0_gnt, p1_gnt}, 2'b00);
            check_eq("rst_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
            check_eq("rst_strobes", {dm_we, io_we, io_rd}, 3'b000);
            check_eq("rst_rdata0", p0_rdata, 32'd0);
            check_eq("rst_rdata1", p1_rdata, 32'd0);
        end
        rstn = 1'b1;
        model_reset();
        apply();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        rr_en = 1'b1;
        dm_dout = '0; io_din = '0; dm_error = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b0; we_s[i] = 1'b0; mode_s[i] = '0;
            addr_s[i] = '0; wdata_s[i] = '0;
        end
        cyc = 0;
        model_reset();
        apply();
        p0_req = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("reset_gnt", {p0_gnt, p1_gnt}, 2'b00);
        check_eq("reset_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
        check_eq("reset_strobes", {dm_we, io_we, io_rd, p_err}, 4'b0000);
        check_eq("reset_dm_addr", dm_addr, 32'd0);
        check_eq("reset_rdata0", p0_rdata, 32'd0);
        check_eq("reset_rdata1", p1_rdata, 32'd0);
        p0_req = 1'b0;
        rstn = 1'b1;

        directed(0, 1'b0, 32'h0000_0010, 32'h0);
        directed(1, 1'b1, 32'h0000_FF04, 32'h0000_005A);
        run(400, 40, 3, 5);
        rr_en = 1'b1;
        run(60, 100, 0, 0);
        rr_en = 1'b0;
        run(60, 100, 0, 0);
        reset_mid_access();
        run(400, 50, 3, 8);
        rr_en = 1'b1;
        run(30, 100, 0, 0);

`ifdef DMU_ARB_STATS_EN
        #1;
        check_eq("p0_cnt", p0_cnt, n_gnt[0]);
        check_eq("p1_cnt", p1_cnt, n_gnt[1]);
        check_eq("io_cnt", io_cnt, n_io);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
